// File: rtl/gt_rx_capture.sv
// rtl/gt_rx_capture.sv - GT RX stream capture into dual-clock SRAM with masked pattern trigger
module gt_rx_capture #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              gt_clk,
  input  logic              gt_rstb,
  input  logic              ps_clk,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              cap_arm,
  input  logic              cap_abort,
  input  logic [ADDR_W-1:0] cap_len,
  input  logic              trig_mode,
  input  logic [DATA_W-1:0] trig_pattern,
  input  logic [DATA_W-1:0] trig_mask,
  output logic              cap_busy,
  output logic              cap_done,
  output logic [ADDR_W:0]   cap_count,
  output logic [15:0]       trig_wait,
  input  logic [ADDR_W-1:0] ps_raddr,
  output logic [DATA_W-1:0] ps_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     cap_count_q, cap_count_d;
  logic [15:0]         trig_wait_q, trig_wait_d;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic                trig_match;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign trig_match = s_tvalid && (((s_tdata ^ trig_pattern) & trig_mask) == '0);

  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      cap_count_q <= '0;
      trig_wait_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      cap_count_q <= cap_count_d;
      trig_wait_q <= trig_wait_d;
    end
  end

  // Abort outranks arm; arm outranks whatever the current state would do.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    cap_count_d = cap_count_q;
    trig_wait_d = trig_wait_q;
    ram_we      = 1'b0;
    ram_waddr   = wr_addr_q;
    if (cap_abort) begin
      state_d = IDLE;
    end else if (cap_arm) begin
      wr_addr_d   = '0;
      cap_count_d = '0;
      trig_wait_d = '0;
      state_d     = trig_mode ? WAIT_TRIG : CAPTURE;
    end else begin
      case (state_q)
        WAIT_TRIG: begin
          if (trig_match) begin
            // The matching word itself is the first stored word.
            ram_we      = 1'b1;
            ram_waddr   = '0;
            cap_count_d = (ADDR_W+1)'(1);
            if (cap_len == '0) begin
              state_d = DONE;
            end else begin
              state_d   = CAPTURE;
              wr_addr_d = ADDR_W'(1);
            end
          end else if (trig_wait_q != 16'hFFFF) begin
            trig_wait_d = trig_wait_q + 16'd1;
          end
        end
        CAPTURE: begin
          if (s_tvalid) begin
            ram_we      = 1'b1;
            cap_count_d = cap_count_q + (ADDR_W+1)'(1);
            if (wr_addr_q == cap_len) begin
              state_d = DONE;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge gt_clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= s_tdata;
    end
  end

  always_ff @(posedge ps_clk) begin
    ps_rdata <= mem[ps_raddr];
  end

  assign cap_busy  = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
  assign cap_done  = (state_q == DONE);
  assign cap_count = cap_count_q;
  assign trig_wait = trig_wait_q;

endmodule

// File: doc/gt_rx_capture.md
# gt_rx_capture

Receive-side companion to the GT transmit pattern path. Takes the GT RX AXI-stream word flow in the gt_clk domain and captures a programmable number of words into an internal dual-clock SRAM, either immediately or after a masked pattern trigger. The PS reads the captured words back through a ps_clk read port behind the AXI-lite register block. Status outputs are gt_clk-domain levels; the register block synchronizes them.

## Interface

- ADDR_W, 8, SRAM address width; depth 2^ADDR_W words
- DATA_W, 32, stream and SRAM word width

- gt_clk  in  1  capture clock; RAM write port, FSM, status
- gt_rstb  in  1  reset, asynchronous, active-low
- ps_clk  in  1  RAM read-port clock; no reset in this domain
- s_tdata  in  DATA_W  GT RX data
- s_tvalid  in  1  word valid; no backpressure, so no tready
- cap_arm  in  1  single-cycle pulse; start or restart a capture
- cap_abort  in  1  single-cycle pulse; cancel to IDLE
- cap_len  in  ADDR_W  index of the last word to capture; captures cap_len+1 words
- trig_mode  in  1  0 = immediate, 1 = wait for pattern
- trig_pattern  in  DATA_W  trigger compare value
- trig_mask  in  DATA_W  1 = bit participates in compare
- cap_busy  out  1  high in WAIT_TRIG or CAPTURE
- cap_done  out  1  high in DONE
- cap_count  out  ADDR_W+1  words written in the current capture
- trig_wait  out  16  gt_clk cycles spent in WAIT_TRIG; saturates at 0xFFFF
- ps_raddr  in  ADDR_W  PS read address
- ps_rdata  out  DATA_W  RAM word at ps_raddr, registered

## Operation

- FSM states: IDLE, WAIT_TRIG, CAPTURE, DONE. Reset state is IDLE.
- Trigger match: s_tvalid && (((s_tdata ^ trig_pattern) & trig_mask) == 0). A trig_mask of 0 matches the first valid word.
- cap_arm in any state:
  - wr_addr, cap_count and trig_wait clear to 0.
  - Next state is CAPTURE if trig_mode = 0, otherwise WAIT_TRIG.
  - Arming while busy restarts the capture; the RAM is not cleared.
- cap_abort in any state goes to IDLE and leaves cap_count and trig_wait held. If cap_abort and cap_arm arrive in the same cycle, abort wins.
- WAIT_TRIG:
  - trig_wait increments each cycle, saturating.
  - On a match, the matching word is written at address 0 and cap_count becomes 1.
  - If cap_len = 0 the next state is DONE; otherwise the next state is CAPTURE with wr_addr = 1.
- CAPTURE:
  - Each s_tvalid writes s_tdata at wr_addr and increments cap_count.
  - If wr_addr == cap_len the next state is DONE; otherwise wr_addr increments.
  - Cycles with s_tvalid = 0 write nothing; gaps are allowed.
- DONE: holds until cap_arm or cap_abort. Incoming words are ignored.
- cap_len, trig_mode, trig_pattern and trig_mask are sampled live. Software must keep them static while cap_busy is high.
- wr_addr never exceeds cap_len, so there is no wrap-around. cap_len = 2^ADDR_W−1 fills the whole RAM, and cap_count reaches 2^ADDR_W with no overflow because it is ADDR_W+1 bits wide.
- RAM: simple dual-port, inferred as block RAM. Write port is on gt_clk; read port is on ps_clk. RAM contents are not reset. Reading while a capture is in progress is allowed but returns unspecified (mixed old/new) data.

## Timing

- Reset values: cap_busy = 0, cap_done = 0, cap_count = 0, trig_wait = 0, wr_addr = 0, state IDLE. ps_rdata is not reset and is undefined until the first ps_clk edge.
- cap_arm sampled at edge N sets the new state at N. The word presented in the same cycle as cap_arm is never captured. The first capturable word is the one at edge N+1.
- A write, the cap_count increment and the state change all occur on the same gt_clk edge as the accepted word.
- cap_done rises on the edge that writes the final word. cap_busy falls on that same edge.
- Trigger latency is zero: the matching word itself is stored at address 0.
- ps_rdata is valid one ps_clk edge after ps_raddr is sampled.
- Data written at gt_clk edge N is guaranteed readable on ps_clk once the register block has observed the synchronized cap_done.

## Test plan

- Immediate mode: trig_mode = 0, cap_len = 3, continuous words 0x10..0x17 starting the cycle after arm. Required: RAM[0..3] = 0x10..0x13; cap_done rises on the 4th word; cap_count = 4; PS reads back the same values.
- Pattern trigger: trig_mode = 1, pattern 0xA5000000, mask 0xFF000000, cap_len = 2. Stream 1, 2, 0xA5001234, 7, 8, 9. Required: RAM = {0xA5001234, 7, 8}; trig_wait = 2; cap_count = 3.
- Gaps and single word:
  - cap_len = 0 with trig_mode = 0: exactly 1 word is captured and DONE is reached on that edge.
  - cap_len = 5 with s_tvalid toggling: only the 6 valid words are stored, in order.
- Full depth: cap_len = 255 with a ramp 0..255. Required: cap_count = 256, no wrap, RAM[i] = i.
- Abort and re-arm:
  - cap_abort mid-CAPTURE: next state IDLE, cap_done stays 0, cap_count held.
  - cap_arm and cap_abort in the same cycle: IDLE.
  - cap_arm during CAPTURE: counters clear and the capture restarts at address 0.
- Async reset mid-capture: gt_rstb asserted low at an arbitrary phase. Required: all outputs reach their reset values immediately; after release, a new arm captures normally.
